sobel_pipeline: RTL and testbench
=================================

SOBEL_PIPELINE -- requirements
Module: sobel_pipeline

Interface
REQ-001 Parameter WIDTH_P, default 640, pixels per image row; SHALL be >= 3.
REQ-002 Parameter HEIGHT_P, default 480, rows per image; SHALL be >= 3.
REQ-003 Port clk_i, input, 1, sole clock; all state SHALL update on its rising edge.
REQ-004 Port reset_i, input, 1; one clock; reset is synchronous and active-low.
REQ-005 Port valid_i, input, 1, pixel_i carries a valid input pixel this cycle.
REQ-006 Port pixel_i, input, 8, unsigned grayscale input pixel, raster order (x fastest, then y).
REQ-007 Port valid_o, output, 1, pixel_o carries a valid filtered pixel this cycle.
REQ-008 Port pixel_o, output, 8, unsigned Sobel magnitude, raster order.

Function
REQ-009 The block SHALL accept one pixel per cycle when valid_i=1; there is no backpressure, and the next accepted pixel after reset or frame completion is (0,0).
REQ-010 The block SHALL emit exactly WIDTH_P*HEIGHT_P outputs per frame, in raster order, output k corresponding to input k.
REQ-011 For interior pixel (x,y), with p(dx,dy)=input(x+dx,y+dy): Gx = p(1,-1)+2p(1,0)+p(1,1) - p(-1,-1)-2p(-1,0)-p(-1,1); Gy = p(-1,1)+2p(0,1)+p(1,1) - p(-1,-1)-2p(0,-1)-p(1,-1).
REQ-012 Gx, Gy SHALL be computed as 11-bit signed (range +/-1020) without overflow; magnitude = |Gx|+|Gy| (0..2040), saturated to 255 for pixel_o.
REQ-013 Border pixels (x=0, x=WIDTH_P-1, y=0, y=HEIGHT_P-1) SHALL output 0x00; the window SHALL never mix pixels across row or frame boundaries into an output value.
REQ-014 Internal stream SHALL advance one "step" per cycle when valid_i=1 (or during flush); two WIDTH_P-deep 8-bit line buffers plus a 3x3 window register hold the neighbourhood.
REQ-015 Output k SHALL be asserted exactly 2 cycles after the step that ingests stream index k+WIDTH_P+1; with continuous input from cycle 0, output k appears at cycle k+WIDTH_P+3.
REQ-016 When valid_i=0 mid-frame, the pipeline SHALL stall (no step), producing no new outputs beyond those already in the 2 compute stages; output values SHALL be independent of input gaps.
REQ-017 After the last frame pixel is accepted, the block SHALL enter flush: WIDTH_P+1 steps on consecutive cycles injecting zero pixels, so the final outputs complete without further input.
REQ-018 valid_i asserted during flush SHALL be ignored (pixel dropped); after the last output the block SHALL return to idle with counters cleared, ready for the next frame.
REQ-019 pixel_o SHALL be registered and read 0x00 whenever valid_o=0.
REQ-020 State: IDLE/RUN (accepting), FLUSH (draining), back to IDLE after output WIDTH_P*HEIGHT_P-1; input x/y counters and output x/y counters wrap at WIDTH_P/HEIGHT_P.

Reset
REQ-021 While reset_i=0 at a rising edge: valid_o=0, pixel_o=0, all counters 0, state IDLE, compute pipeline valids cleared; line-buffer contents need not be cleared.
REQ-022 Reset mid-frame or mid-flush SHALL abort the frame; no stale outputs SHALL appear after release; first pixel accepted after release is (0,0).

Verification (WIDTH_P=8, HEIGHT_P=4 unless stated)
REQ-023 Constant image 0x80, continuous valid_i from cycle 0 -> 32 outputs all 0x00; first valid_o at cycle 11, last at cycle 42, contiguous.
REQ-024 Vertical step (x<4: 0x00, x>=4: 0xFF) -> rows 1-2, x=3 and x=4 output 0xFF (|Gx|=1020 saturated); other pixels 0x00.
REQ-025 Ramp pixel=x*4 -> interior outputs 0x20 (Gx=32, Gy=0); borders 0x00.
REQ-026 Same ramp with valid_i toggling 1,0,1,0 -> identical output sequence to REQ-025, 32 outputs total, after final pixel outputs drain without input within WIDTH_P+3 cycles.
REQ-027 Reset (reset_i=0 for 2 cycles) after 13 pixels accepted, then a full constant frame -> exactly 32 outputs, all 0x00, no outputs from the aborted frame.
REQ-028 Default parameters, 640x480 random image, continuous input -> 307200 outputs matching a reference model bit-exactly, all complete within 2*640 cycles after last input.

Source files
------------

// File: rtl/sobel_pipeline.sv
// ---------------------------------------------------------------------------
// sobel_pipeline
//
// Streaming 3x3 Sobel edge-magnitude filter for a raster-order grayscale
// image of WIDTH_P x HEIGHT_P pixels. Each accepted pixel advances the stream
// by one step. Two line buffers plus a 3x3 window register form the
// neighbourhood, and one registered compute stage produces the output.
// Output k, for the pixel at stream index k, is produced two cycles after the
// step that ingests stream index k+WIDTH_P+1. Once the last frame pixel has
// been accepted, the block injects WIDTH_P+1 zero pixels on its own. This
// flush lets the bottom rows complete without further input.
//
// Ports:
//   clk_i    : sole clock, rising edge
//   reset_i  : synchronous, active-low reset
//   valid_i  : pixel_i holds a valid input pixel this cycle
//   pixel_i  : 8-bit unsigned grayscale input pixel
//   valid_o  : pixel_o holds a valid filtered pixel this cycle
//   pixel_o  : 8-bit saturated |Gx|+|Gy|, reads 0 when valid_o is low
// ---------------------------------------------------------------------------
module sobel_pipeline #(
    parameter int WIDTH_P  = 640,
    parameter int HEIGHT_P = 480
) (
    input  logic       clk_i,
    input  logic       reset_i,
    input  logic       valid_i,
    input  logic [7:0] pixel_i,
    output logic       valid_o,
    output logic [7:0] pixel_o
);

    localparam int CNT_W = $clog2(WIDTH_P * HEIGHT_P + WIDTH_P + 2);
    localparam int X_W   = $clog2(WIDTH_P);
    localparam int Y_W   = $clog2(HEIGHT_P);

    localparam logic [CNT_W-1:0] LAST_IN    = CNT_W'(WIDTH_P * HEIGHT_P - 1);
    localparam logic [CNT_W-1:0] FIRST_EMIT = CNT_W'(WIDTH_P + 1);
    localparam logic [CNT_W-1:0] LAST_STEP  = CNT_W'(WIDTH_P * HEIGHT_P + WIDTH_P);
    localparam logic [X_W-1:0]   X_MAX      = X_W'(WIDTH_P - 1);
    localparam logic [Y_W-1:0]   Y_MAX      = Y_W'(HEIGHT_P - 1);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_RUN   = 2'd1;
    localparam logic [1:0] ST_FLUSH = 2'd2;

    logic [1:0]       state_q, state_d;
    logic [CNT_W-1:0] stepCnt_q, stepCnt_d;
    logic [X_W-1:0]   colX_q, colX_d;
    logic [X_W-1:0]   outX_q, outX_d;
    logic [Y_W-1:0]   outY_q, outY_d;
    logic             winValid_q, winValid_d;
    logic             valid_q, valid_d;
    logic [7:0]       pix_q, pix_d;

    logic [7:0] lineBuf1 [WIDTH_P];
    logic [7:0] lineBuf2 [WIDTH_P];
    logic [7:0] win_q [3][3];

    logic       acceptIn;
    logic       flushStep;
    logic       step;
    logic [7:0] stepPix;
    logic       lastOut;
    logic       border;

    logic [9:0]         gxPos, gxNeg, gyPos, gyNeg;
    logic signed [10:0] gx, gy;
    logic [9:0]         absGx, absGy;
    logic [10:0]        mag;
    logic [7:0]         magSat;

    // A step happens for every accepted input pixel. It also happens on each
    // flush cycle until the last padding pixel, stream index
    // W*H+W, has been ingested.
    always_comb begin
        acceptIn  = valid_i && (state_q != ST_FLUSH);
        flushStep = (state_q == ST_FLUSH) && (stepCnt_q <= LAST_STEP);
        step      = acceptIn || flushStep;
        stepPix   = flushStep ? 8'h00 : pixel_i;
        lastOut   = winValid_q && (outX_q == X_MAX) && (outY_q == Y_MAX);
    end

    // Sobel kernels on the window. Row 0 is the top row and column 2 is the
    // newest column. The window centre sits at win_q[1][1]. Positive and
    // negative halves are unsigned sums, so no intermediate can overflow.
    always_comb begin
        gxPos  = {2'b00, win_q[0][2]} + {1'b0, win_q[1][2], 1'b0} + {2'b00, win_q[2][2]};
        gxNeg  = {2'b00, win_q[0][0]} + {1'b0, win_q[1][0], 1'b0} + {2'b00, win_q[2][0]};
        gyPos  = {2'b00, win_q[2][0]} + {1'b0, win_q[2][1], 1'b0} + {2'b00, win_q[2][2]};
        gyNeg  = {2'b00, win_q[0][0]} + {1'b0, win_q[0][1], 1'b0} + {2'b00, win_q[0][2]};
        gx     = $signed({1'b0, gxPos}) - $signed({1'b0, gxNeg});
        gy     = $signed({1'b0, gyPos}) - $signed({1'b0, gyNeg});
        absGx  = gx[10] ? 10'(-gx) : gx[9:0];
        absGy  = gy[10] ? 10'(-gy) : gy[9:0];
        mag    = {1'b0, absGx} + {1'b0, absGy};
        magSat = (|mag[10:8]) ? 8'hFF : mag[7:0];
        border = (outX_q == '0) || (outX_q == X_MAX) || (outY_q == '0) || (outY_q == Y_MAX);
    end

    // Frame control. The window holds a real centre pixel only once stream
    // index W+1 has been ingested. From then on, every step emits exactly one
    // output. The block leaves FLUSH only when the final output is committed,
    // so a new frame never overlaps a draining one.
    always_comb begin
        state_d    = state_q;
        stepCnt_d  = stepCnt_q;
        colX_d     = colX_q;
        outX_d     = outX_q;
        outY_d     = outY_q;
        winValid_d = step && (stepCnt_q >= FIRST_EMIT);
        valid_d    = winValid_q;
        pix_d      = 8'h00;

        if (step) begin
            stepCnt_d = stepCnt_q + 1'b1;
            colX_d    = (colX_q == X_MAX) ? '0 : colX_q + 1'b1;
        end

        if (winValid_q) begin
            pix_d  = border ? 8'h00 : magSat;
            outX_d = (outX_q == X_MAX) ? '0 : outX_q + 1'b1;
            if (outX_q == X_MAX) begin
                outY_d = (outY_q == Y_MAX) ? '0 : outY_q + 1'b1;
            end
        end

        case (state_q)
            ST_IDLE, ST_RUN: begin
                if (acceptIn) begin
                    state_d = (stepCnt_q == LAST_IN) ? ST_FLUSH : ST_RUN;
                end
            end
            ST_FLUSH: begin
                if (lastOut) begin
                    state_d   = ST_IDLE;
                    stepCnt_d = '0;
                    colX_d    = '0;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Control and output registers. Reset clears every valid flag, so a
    // frame in flight is aborted with nothing left to drain.
    always_ff @(posedge clk_i) begin
        if (!reset_i) begin
            state_q    <= ST_IDLE;
            stepCnt_q  <= '0;
            colX_q     <= '0;
            outX_q     <= '0;
            outY_q     <= '0;
            winValid_q <= 1'b0;
            valid_q    <= 1'b0;
            pix_q      <= 8'h00;
        end else begin
            state_q    <= state_d;
            stepCnt_q  <= stepCnt_d;
            colX_q     <= colX_d;
            outX_q     <= outX_d;
            outY_q     <= outY_d;
            winValid_q <= winValid_d;
            valid_q    <= valid_d;
            pix_q      <= pix_d;
        end
    end

    // Line buffers and window have no reset, so they can map to memory.
    // The new column is {two rows up, one row up, current pixel} at the
    // same x. Stale contents never reach an output, because valid starts
    // only after a full refill.
    always_ff @(posedge clk_i) begin
        if (reset_i && step) begin
            lineBuf1[colX_q] <= stepPix;
            lineBuf2[colX_q] <= lineBuf1[colX_q];
            for (int r = 0; r < 3; r++) begin
                win_q[r][0] <= win_q[r][1];
                win_q[r][1] <= win_q[r][2];
            end
            win_q[0][2] <= lineBuf2[colX_q];
            win_q[1][2] <= lineBuf1[colX_q];
            win_q[2][2] <= stepPix;
        end
    end

    assign valid_o = valid_q;
    assign pixel_o = pix_q;

endmodule

// File: tb/tb_sobel_pipeline.sv
// ---------------------------------------------------------------------------
// tb_sobel_pipeline
//
// Directed bench for sobel_pipeline on an 8x4 image. A negedge monitor
// records every output pixel with its cycle number. Each frame is then
// compared against expected values built by the bench. Most tests use
// hand-written rules. The random frame uses a plain 2-D convolution model.
// ---------------------------------------------------------------------------
module tb_sobel_pipeline;

    localparam int W = 8;
    localparam int H = 4;
    localparam int N = W * H;

    logic       clk_i   = 1'b0;
    logic       reset_i = 1'b0;
    logic       valid_i = 1'b0;
    logic [7:0] pixel_i = 8'h00;
    logic       valid_o;
    logic [7:0] pixel_o;

    int errors = 0;
    int checks = 0;
    int cyc    = 0;

    int obsVal[$];
    int obsCyc[$];
    int idleNonZero = 0;

    logic [7:0] img [N];
    int         expVal [N];

    sobel_pipeline #(.WIDTH_P(W), .HEIGHT_P(H)) dut (
        .clk_i   (clk_i),
        .reset_i (reset_i),
        .valid_i (valid_i),
        .pixel_i (pixel_i),
        .valid_o (valid_o),
        .pixel_o (pixel_o)
    );

    always #5 clk_i = ~clk_i;

    always @(posedge clk_i) cyc <= cyc + 1;

    // Capture outputs mid-cycle, away from the active edge
    always @(negedge clk_i) begin
        if (valid_o === 1'b1) begin
            obsVal.push_back(int'(pixel_o));
            obsCyc.push_back(cyc);
        end else if (pixel_o !== 8'h00) begin
            idleNonZero++;
        end
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        if (observed !== expected) begin
            errors++;
            $display("[TB] FAIL %s: observed %0d expected %0d", tag, observed, expected);
        end
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    function automatic int pix(input int x, input int y);
        return int'(img[y * W + x]);
    endfunction

    // Reference Sobel on the whole image: borders 0, interior |Gx|+|Gy| capped at 255
    function automatic int sobelRef(input int x, input int y);
        int gx, gy, m;
        if (x == 0 || x == W - 1 || y == 0 || y == H - 1) return 0;
        gx = pix(x+1,y-1) + 2*pix(x+1,y) + pix(x+1,y+1) - pix(x-1,y-1) - 2*pix(x-1,y) - pix(x-1,y+1);
        gy = pix(x-1,y+1) + 2*pix(x,y+1) + pix(x+1,y+1) - pix(x-1,y-1) - 2*pix(x,y-1) - pix(x+1,y-1);
        m  = (gx < 0 ? -gx : gx) + (gy < 0 ? -gy : gy);
        return (m > 255) ? 255 : m;
    endfunction

    // mode 0 constant 0x80, 1 vertical step, 2 ramp x*4, 3 random
    task automatic buildFrame(input int mode);
        for (int y = 0; y < H; y++) begin
            for (int x = 0; x < W; x++) begin
                bit interior;
                interior = (x > 0) && (x < W - 1) && (y > 0) && (y < H - 1);
                case (mode)
                    0: begin img[y*W+x] = 8'h80; expVal[y*W+x] = 0; end
                    1: begin
                        img[y*W+x]    = (x < 4) ? 8'h00 : 8'hFF;
                        expVal[y*W+x] = (interior && (x == 3 || x == 4)) ? 255 : 0;
                    end
                    2: begin img[y*W+x] = 8'(x * 4); expVal[y*W+x] = interior ? 32 : 0; end
                    default: img[y*W+x] = 8'($urandom_range(0, 255));
                endcase
            end
        end
        if (mode == 3) begin
            for (int y = 0; y < H; y++)
                for (int x = 0; x < W; x++)
                    expVal[y*W+x] = sobelRef(x, y);
        end
    endtask

    // Drive one frame, then idle (or junk-valid during flush) until it drains
    task automatic applyStimulus(input bit gapped, input bit junkInFlush, input bit clearQ,
                                 output int firstCyc, output int lastInCyc);
        if (clearQ) begin
            obsVal.delete();
            obsCyc.delete();
        end
        idleNonZero = 0;
        firstCyc    = cyc;
        lastInCyc   = cyc;
        for (int i = 0; i < N; i++) begin
            valid_i   = 1'b1;
            pixel_i   = img[i];
            lastInCyc = cyc;
            tick();
            if (gapped && i != N - 1) begin
                valid_i = 1'b0;
                pixel_i = 8'hA5;
                tick();
            end
        end
        for (int c = 0; c < 4 * W; c++) begin
            valid_i = junkInFlush && (c < W + 1);
            pixel_i = 8'hEE;
            tick();
            if (obsVal.size() >= N && c >= W + 1) break;
        end
        valid_i = 1'b0;
        pixel_i = 8'h00;
        repeat (3) tick();
    endtask

    task automatic checkFrame(input string name, input int lastInCyc);
        int got;
        checkOutput({name, "_count"}, obsVal.size(), N);
        for (int i = 0; i < N; i++) begin
            got = (i < obsVal.size()) ? obsVal[i] : -1;
            checkOutput($sformatf("%s_px%0d", name, i), got, expVal[i]);
        end
        if (obsCyc.size() > 0)
            checkOutput({name, "_drain"}, (obsCyc[obsCyc.size()-1] - lastInCyc) <= W + 3, 1);
        else
            checkOutput({name, "_drain"}, 0, 1);
        checkOutput({name, "_idlezero"}, idleNonZero, 0);
    endtask

    initial begin
        int firstCyc, lastInCyc;

        // Reset state
        reset_i = 1'b0;
        repeat (3) tick();
        checkOutput("reset_valid", valid_o, 0);
        checkOutput("reset_pixel", pixel_o, 0);
        reset_i = 1'b1;
        tick();

        // Constant frame, continuous: first output at cycle 11, last at 42
        buildFrame(0);
        applyStimulus(1'b0, 1'b0, 1'b1, firstCyc, lastInCyc);
        checkFrame("const", lastInCyc);
        if (obsCyc.size() == N) begin
            checkOutput("const_first_cyc", obsCyc[0] - firstCyc, W + 3);
            checkOutput("const_last_cyc", obsCyc[N-1] - firstCyc, N + W + 2);
            checkOutput("const_contig", obsCyc[N-1] - obsCyc[0], N - 1);
        end else begin
            checkOutput("const_timing_count", obsCyc.size(), N);
        end

        $display("[TB] vertical step");
        buildFrame(1);
        applyStimulus(1'b0, 1'b0, 1'b1, firstCyc, lastInCyc);
        checkFrame("vstep", lastInCyc);

        $display("[TB] ramp");
        buildFrame(2);
        applyStimulus(1'b0, 1'b0, 1'b1, firstCyc, lastInCyc);
        checkFrame("ramp", lastInCyc);

        $display("[TB] ramp with input gaps");
        applyStimulus(1'b1, 1'b0, 1'b1, firstCyc, lastInCyc);
        checkFrame("rampgap", lastInCyc);

        $display("[TB] random frame, junk valid during flush");
        buildFrame(3);
        applyStimulus(1'b0, 1'b1, 1'b1, firstCyc, lastInCyc);
        checkFrame("rand", lastInCyc);

        $display("[TB] ramp after junk flush restarts at (0,0)");
        buildFrame(2);
        applyStimulus(1'b0, 1'b0, 1'b1, firstCyc, lastInCyc);
        checkFrame("ramp2", lastInCyc);

        $display("[TB] reset abort after 13 pixels");
        buildFrame(2);
        for (int i = 0; i < 13; i++) begin
            valid_i = 1'b1;
            pixel_i = img[i];
            tick();
        end
        valid_i = 1'b0;
        reset_i = 1'b0;
        tick();
        obsVal.delete();
        obsCyc.delete();
        tick();
        reset_i = 1'b1;
        buildFrame(0);
        applyStimulus(1'b0, 1'b0, 1'b0, firstCyc, lastInCyc);
        checkFrame("abort", lastInCyc);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
